// File: rtl/common_pkg.sv
// Instruction-bus request/response types shared by every bus master and slave.
package common_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage types: fetch FSM states, sequential PC step and the fetch->decode payload.
package pipes_pkg;

  typedef enum logic [1:0] {REQ = 2'd0, OUT = 2'd1, DROP = 2'd2} fetch_state_t;

  localparam logic [63:0] PC_STEP = 64'd4;

  // CTL_NONE must stay zero so an all-zero instruction decodes to an all-zero payload
  typedef enum logic [3:0] {
    CTL_NONE, CTL_ALU, CTL_ALUI, CTL_LOAD, CTL_STORE,
    CTL_BRANCH, CTL_JAL, CTL_JALR, CTL_LUI, CTL_AUIPC
  } ctl_op_t;

  typedef struct packed {
    ctl_op_t op;
    logic    reg_write;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    ctl_t        ctl;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dst;
    logic [63:0] imm;
  } fetch_data_t;

endpackage

// File: rtl/fetch_decoder.sv
// Combinational RV-style decode of the latched instruction into ctl/register fields/immediate.
module fetch_decoder
  import pipes_pkg::*;
(
  input  logic [31:0] instr,
  output ctl_t        ctl,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  output logic [4:0]  dst,
  output logic [63:0] imm
);

  always_comb begin
    ctl = '{op: CTL_NONE, reg_write: 1'b0};
    imm = '0;
    ra1 = instr[19:15];
    ra2 = instr[24:20];
    dst = instr[11:7];
    case (instr[6:0])
      7'h33: ctl = '{op: CTL_ALU, reg_write: 1'b1};
      7'h13: begin
        ctl = '{op: CTL_ALUI, reg_write: 1'b1};
        imm = {{52{instr[31]}}, instr[31:20]};
      end
      7'h03: begin
        ctl = '{op: CTL_LOAD, reg_write: 1'b1};
        imm = {{52{instr[31]}}, instr[31:20]};
      end
      7'h23: begin
        ctl = '{op: CTL_STORE, reg_write: 1'b0};
        imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'h63: begin
        ctl = '{op: CTL_BRANCH, reg_write: 1'b0};
        imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'h6f: begin
        ctl = '{op: CTL_JAL, reg_write: 1'b1};
        imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'h67: begin
        ctl = '{op: CTL_JALR, reg_write: 1'b1};
        imm = {{52{instr[31]}}, instr[31:20]};
      end
      7'h37: begin
        ctl = '{op: CTL_LUI, reg_write: 1'b1};
        imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      end
      7'h17: begin
        ctl = '{op: CTL_AUIPC, reg_write: 1'b1};
        imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC register, ibus request FSM, latched and decoded output.
// Define FETCH_PREFETCH_EN for a one-entry prefetch buffer giving back-to-back delivery.
module fetch
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h8000_0000,
  parameter logic [63:0] PC_STEP  = pipes_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output fetch_data_t dataF
);

  fetch_state_t state, state_n;
  logic        started, req_live, fv, fv_n;
  logic [63:0] pc, pc_n, hold, hold_n, dpc, dpc_n;
  logic [31:0] raw, raw_n;
  logic        unused_addr_ok;
  ctl_t        ctl;
  logic [4:0]  ra1, ra2, dst;
  logic [63:0] imm;
`ifdef FETCH_PREFETCH_EN
  logic        bv, bv_n;
  logic [63:0] bpc, bpc_n;
  logic [31:0] braw, braw_n;
`endif

  assign unused_addr_ok = iresp.addr_ok;
  // hold keeps the outstanding address on the bus while pc already tracks the redirect
  assign req_live    = started && (state != OUT);
  assign ireq        = '{valid: req_live, addr: (state == DROP) ? hold : pc};
  assign fetch_valid = fv;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    hold_n  = hold;
    fv_n    = fv;
    dpc_n   = dpc;
    raw_n   = raw;
`ifdef FETCH_PREFETCH_EN
    bv_n    = bv;
    bpc_n   = bpc;
    braw_n  = braw;
    if (redirect_valid) begin
      fv_n    = 1'b0;
      bv_n    = 1'b0;
      pc_n    = redirect_pc;
      hold_n  = ireq.addr;
      state_n = (req_live && !iresp.data_ok) ? DROP : REQ;
    end else begin
      if (fv && fetch_ready) begin
        fv_n  = bv;
        dpc_n = bpc;
        raw_n = braw;
        bv_n  = 1'b0;
      end
      // pc is the next address to request; it advances as each response lands
      if (state == REQ && req_live && iresp.data_ok) begin
        if (!fv_n) begin
          fv_n  = 1'b1;
          dpc_n = pc;
          raw_n = iresp.data;
        end else begin
          bv_n   = 1'b1;
          bpc_n  = pc;
          braw_n = iresp.data;
        end
        pc_n = pc + PC_STEP;
      end
      if (state == DROP) state_n = iresp.data_ok ? REQ : DROP;
      else               state_n = (fv_n && bv_n) ? OUT : REQ;
    end
`else
    case (state)
      REQ:
        if (redirect_valid) begin
          pc_n   = redirect_pc;
          hold_n = pc;
          if (req_live && !iresp.data_ok) state_n = DROP;
        end else if (req_live && iresp.data_ok) begin
          state_n = OUT;
          fv_n    = 1'b1;
          dpc_n   = pc;
          raw_n   = iresp.data;
        end
      DROP: begin
        if (redirect_valid) pc_n = redirect_pc;
        if (iresp.data_ok) state_n = REQ;
      end
      OUT:
        if (redirect_valid || fetch_ready) begin
          pc_n    = redirect_valid ? redirect_pc : pc + PC_STEP;
          fv_n    = 1'b0;
          state_n = REQ;
        end
      default: state_n = REQ;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= REQ;
      started <= 1'b0;
      pc      <= PC_RESET;
      hold    <= PC_RESET;
      fv      <= 1'b0;
      dpc     <= '0;
      raw     <= '0;
`ifdef FETCH_PREFETCH_EN
      bv      <= 1'b0;
      bpc     <= '0;
      braw    <= '0;
`endif
    end else begin
      state   <= state_n;
      started <= 1'b1;
      pc      <= pc_n;
      hold    <= hold_n;
      fv      <= fv_n;
      dpc     <= dpc_n;
      raw     <= raw_n;
`ifdef FETCH_PREFETCH_EN
      bv      <= bv_n;
      bpc     <= bpc_n;
      braw    <= braw_n;
`endif
    end
  end

  fetch_decoder u_dec (
    .instr (raw),
    .ctl   (ctl),
    .ra1   (ra1),
    .ra2   (ra2),
    .dst   (dst),
    .imm   (imm)
  );

  assign dataF = '{pc: dpc, raw_instr: raw, ctl: ctl, ra1: ra1, ra2: ra2, dst: dst, imm: imm};

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: reset, stall, redirects (in REQ/DROP/OUT), PC wrap, reset mid-request.
module tb_fetch;
  import common_pkg::*;
  import pipes_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  fetch_data_t dataF;

  int checks = 0;
  int errors = 0;

  fetch dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .dataF          (dataF)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    iresp = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fetch_ready = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    iresp = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fetch_ready = 1'b0;
    #3;
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL rst_ireq_valid got=%b exp=0", ireq.valid); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fetch_valid got=%b exp=0", fetch_valid); end
    checks++; if (dataF !== fetch_data_t'(0)) begin errors++; $display("FAIL rst_dataF got=%h exp=0", dataF); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL t1_valid_early got=%b exp=0", ireq.valid); end
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin errors++; $display("FAIL t1_req got=%b/%h exp=1/80000000", ireq.valid, ireq.addr); end
    step();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL t1_fv_wait got=%b exp=0", fetch_valid); end
    iresp.data_ok = 1'b1; iresp.data = 32'h0000_0013;
    step();
    iresp = '0;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL t1_fv got=%b exp=1", fetch_valid); end
    checks++; if (dataF.pc !== 64'h8000_0000 || dataF.raw_instr !== 32'h13) begin errors++; $display("FAIL t1_data got=%h/%h exp=80000000/13", dataF.pc, dataF.raw_instr); end
    checks++; if (dataF.ctl.op !== CTL_ALUI || dataF.ctl.reg_write !== 1'b1 || dataF.imm !== 64'd0) begin errors++; $display("FAIL t1_decode got=%0d/%b/%h exp=2/1/0", dataF.ctl.op, dataF.ctl.reg_write, dataF.imm); end
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL t1_no_req got=%b exp=0", ireq.valid); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (fetch_valid !== 1'b1 || dataF.pc !== 64'h8000_0000 || dataF.raw_instr !== 32'h13) begin errors++; $display("FAIL t2_stall%0d got=%b/%h/%h exp=1/80000000/13", i, fetch_valid, dataF.pc, dataF.raw_instr); end
      checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL t2_noreq%0d got=%b exp=0", i, ireq.valid); end
    end
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL t2_fv_drop got=%b exp=0", fetch_valid); end
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0004) begin errors++; $display("FAIL t2_next got=%b/%h exp=1/80000004", ireq.valid, ireq.addr); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin errors++; $display("FAIL t3_hold%0d got=%b/%h exp=1/80000000", i, ireq.valid, ireq.addr); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL t3_nofv%0d got=%b exp=0", i, fetch_valid); end
      if (i == 2) begin iresp.data_ok = 1'b1; iresp.data = 32'h0010_0093; end
      step();
    end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL t3_dropped got=%b exp=0", fetch_valid); end
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_1000) begin errors++; $display("FAIL t3_newaddr got=%b/%h exp=1/80001000", ireq.valid, ireq.addr); end
    iresp.data = 32'hFFF0_0093;
    step();
    iresp = '0;
    checks++; if (fetch_valid !== 1'b1 || dataF.pc !== 64'h8000_1000) begin errors++; $display("FAIL t3_fetch got=%b/%h exp=1/80001000", fetch_valid, dataF.pc); end
    checks++; if (dataF.imm !== 64'hFFFF_FFFF_FFFF_FFFF || dataF.dst !== 5'd1 || dataF.ra1 !== 5'd0) begin errors++; $display("FAIL t3_decode got=%h/%0d/%0d exp=ffffffffffffffff/1/0", dataF.imm, dataF.dst, dataF.ra1); end
  endtask

  task automatic test_redirect_same_cycle();
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    checks++; if (ireq.addr !== 64'h8000_1004) begin errors++; $display("FAIL t4_seq got=%h exp=80001004", ireq.addr); end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    iresp.data_ok = 1'b1; iresp.data = 32'h0000_0013;
    step();
    redirect_valid = 1'b0; iresp = '0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL t4_discard got=%b exp=0", fetch_valid); end
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_2000) begin errors++; $display("FAIL t4_addr got=%b/%h exp=1/80002000", ireq.valid, ireq.addr); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    iresp.data_ok = 1'b1; iresp.data = 32'h0000_0013;
    step();
    redirect_valid = 1'b0;
    checks++; if (ireq.addr !== 64'hFFFF_FFFF_FFFF_FFFC || fetch_valid !== 1'b0) begin errors++; $display("FAIL t5_top got=%h/%b exp=fffffffffffffffc/0", ireq.addr, fetch_valid); end
    step();
    iresp = '0;
    checks++; if (fetch_valid !== 1'b1 || dataF.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL t5_fv got=%b/%h exp=1/fffffffffffffffc", fetch_valid, dataF.pc); end
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h0) begin errors++; $display("FAIL t5_wrap got=%b/%h exp=1/0", ireq.valid, ireq.addr); end
  endtask

  task automatic test_redirect_wins();
    iresp.data_ok = 1'b1; iresp.data = 32'h0000_0013;
    step();
    iresp = '0;
    checks++; if (fetch_valid !== 1'b1 || dataF.pc !== 64'h0) begin errors++; $display("FAIL tw_fv got=%b/%h exp=1/0", fetch_valid, dataF.pc); end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000; fetch_ready = 1'b1;
    step();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || ireq.addr !== 64'h8000_3000) begin errors++; $display("FAIL tw_addr got=%b/%h exp=0/80003000", fetch_valid, ireq.addr); end
  endtask

  task automatic test_multi_redirect();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
    step();
    checks++; if (ireq.addr !== 64'h8000_3000) begin errors++; $display("FAIL tm_hold1 got=%h exp=80003000", ireq.addr); end
    redirect_pc = 64'h8000_5000;
    step();
    redirect_valid = 1'b0;
    checks++; if (ireq.addr !== 64'h8000_3000) begin errors++; $display("FAIL tm_hold2 got=%h exp=80003000", ireq.addr); end
    iresp.data_ok = 1'b1;
    step();
    iresp = '0;
    checks++; if (ireq.addr !== 64'h8000_5000 || fetch_valid !== 1'b0) begin errors++; $display("FAIL tm_last got=%h/%b exp=80005000/0", ireq.addr, fetch_valid); end
  endtask

  task automatic test_reset_mid();
    step();
    reset = 1'b0;
    #1;
    checks++; if (ireq.valid !== 1'b0 || fetch_valid !== 1'b0 || dataF !== fetch_data_t'(0)) begin errors++; $display("FAIL t6_async got=%b/%b/%h exp=0/0/0", ireq.valid, fetch_valid, dataF); end
    iresp.data_ok = 1'b1; iresp.data = 32'h0010_0093;
    step();
    reset = 1'b1;
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000 || fetch_valid !== 1'b0) begin errors++; $display("FAIL t6_restart got=%b/%h/%b exp=1/80000000/0", ireq.valid, ireq.addr, fetch_valid); end
    iresp = '0;
    step();
    checks++; if (ireq.addr !== 64'h8000_0000 || fetch_valid !== 1'b0) begin errors++; $display("FAIL t6_ignored got=%h/%b exp=80000000/0", ireq.addr, fetch_valid); end
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic test_back_to_back();
    do_reset();
    step();
    fetch_ready = 1'b1;
    iresp.data_ok = 1'b1; iresp.data = 32'h0000_0013;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) iresp = '0;
      checks++; if (fetch_valid !== 1'b1 || dataF.pc !== 64'h8000_0000 + 64'(4 * i)) begin errors++; $display("FAIL tp_b2b%0d got=%b/%h exp=1/%h", i, fetch_valid, dataF.pc, 64'h8000_0000 + 64'(4 * i)); end
    end
    step();
    fetch_ready = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL tp_end got=%b exp=0", fetch_valid); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FETCH_PREFETCH_EN
    test_back_to_back();
    test_reset_mid();
`else
    test_first_fetch();
    test_stall();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_wrap();
    test_redirect_wins();
    test_multi_redirect();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
